// File: rtl/input_debouncer_pkg.sv
// Shared types and constants for the input debouncer: FSM state encoding,
// glitch-counter width/ceiling and its saturating increment.
package input_debouncer_pkg;

  typedef enum logic {
    ST_STABLE = 1'b0,
    ST_ARM    = 1'b1
  } state_e;

  localparam int             GLITCH_W   = 8;
  localparam logic [GLITCH_W-1:0] GLITCH_MAX = 8'hFF;

  function automatic logic [GLITCH_W-1:0] glitch_sat_inc(input logic [GLITCH_W-1:0] value);
    if (value == GLITCH_MAX) begin
      return value;
    end else begin
      return value + 8'd1;
    end
  endfunction

endpackage

// File: rtl/input_debouncer_if.sv
// Signal bundle between a raw switch source and the debouncer.
// glitch_cnt exists only when DEBOUNCE_GLITCH_COUNT_EN is defined.
interface input_debouncer_if;
  import input_debouncer_pkg::*;

  logic raw_in;
  logic d_out;
  logic rise_pulse;
  logic fall_pulse;
  logic busy;
`ifdef DEBOUNCE_GLITCH_COUNT_EN
  logic [GLITCH_W-1:0] glitch_cnt;

  modport master (output raw_in, input d_out, rise_pulse, fall_pulse, busy, glitch_cnt);
  modport slave  (input raw_in, output d_out, rise_pulse, fall_pulse, busy, glitch_cnt);
`else
  modport master (output raw_in, input d_out, rise_pulse, fall_pulse, busy);
  modport slave  (input raw_in, output d_out, rise_pulse, fall_pulse, busy);
`endif

endinterface

// File: rtl/input_debouncer_sync_chain.sv
// Multi-flop synchronizer bringing an asynchronous level into the clk domain;
// all stages clear to 0 on reset.
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] r_chain;

  // Shift chain, oldest sample at the top bit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_chain <= '0;
    end else begin
      r_chain <= {r_chain[STAGES-2:0], d};
    end
  end

  assign q = r_chain[STAGES-1];

endmodule

// File: rtl/input_debouncer.sv
// Synchronizes a raw switch level, qualifies each change for DEBOUNCE_CYCLES edges
// and drives a clean level plus rise/fall strobes. Optional: DEBOUNCE_GLITCH_COUNT_EN.
module input_debouncer
  import input_debouncer_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic               clk,
  input  logic               reset,
  input_debouncer_if.slave   bus
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             w_sync_q;
  state_e           r_state;
  state_e           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_d_out;
  logic             w_d_out_nxt;
  logic             r_rise;
  logic             w_rise_nxt;
  logic             r_fall;
  logic             w_fall_nxt;
  logic             r_busy;

  sync_chain #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (bus.raw_in),
    .q     (w_sync_q)
  );

  // Next-state, counter and strobe decode
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_d_out_nxt = r_d_out;
    w_rise_nxt  = 1'b0;
    w_fall_nxt  = 1'b0;
    case (r_state)
      ST_STABLE: begin
        if (w_sync_q != r_d_out) begin
          w_state_nxt = ST_ARM;
          w_cnt_nxt   = CNT_ONE;
        end else begin
          w_cnt_nxt   = '0;
        end
      end
      ST_ARM: begin
        if (w_sync_q == r_d_out) begin
          w_state_nxt = ST_STABLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          // This edge is the DEBOUNCE_CYCLES-th consecutive mismatch
          w_d_out_nxt = ~r_d_out;
          w_rise_nxt  = ~r_d_out;
          w_fall_nxt  = r_d_out;
          w_state_nxt = ST_STABLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = ST_STABLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // State, counter and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_STABLE;
      r_cnt   <= '0;
      r_d_out <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_d_out <= w_d_out_nxt;
      r_rise  <= w_rise_nxt;
      r_fall  <= w_fall_nxt;
      r_busy  <= (w_state_nxt == ST_ARM);
    end
  end

  assign bus.d_out      = r_d_out;
  assign bus.rise_pulse = r_rise;
  assign bus.fall_pulse = r_fall;
  assign bus.busy       = r_busy;

`ifdef DEBOUNCE_GLITCH_COUNT_EN
  logic                w_glitch;
  logic [GLITCH_W-1:0] r_glitch_cnt;

  assign w_glitch = (r_state == ST_ARM) && (w_sync_q == r_d_out);

  // Saturating count of aborted qualifications
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_glitch_cnt <= '0;
    end else if (w_glitch) begin
      r_glitch_cnt <= glitch_sat_inc(r_glitch_cnt);
    end else begin
      r_glitch_cnt <= r_glitch_cnt;
    end
  end

  assign bus.glitch_cnt = r_glitch_cnt;
`endif

endmodule

// File: tb/tb_input_debouncer.sv
// Randomized self-checking bench for input_debouncer (SYNC_STAGES=2, DEBOUNCE_CYCLES=4)
// against a run-length reference model; glitch counter checked with DEBOUNCE_GLITCH_COUNT_EN.
module tb_input_debouncer;

  localparam int SYNC = 2;
  localparam int DC   = 4;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  input_debouncer_if bus ();

  input_debouncer #(
    .SYNC_STAGES     (SYNC),
    .DEBOUNCE_CYCLES (DC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: raw samples delayed SYNC edges, run length of disagreement with d_out
  logic raw_q[$];
  logic m_d, m_rise, m_fall, m_busy;
  int   m_run;
`ifdef DEBOUNCE_GLITCH_COUNT_EN
  int   m_glitch;
`endif

  task automatic model_reset();
    raw_q.delete();
    m_d = 1'b0; m_rise = 1'b0; m_fall = 1'b0; m_busy = 1'b0; m_run = 0;
`ifdef DEBOUNCE_GLITCH_COUNT_EN
    m_glitch = 0;
`endif
  endtask

  task automatic model_edge(input logic raw);
    logic s;
    raw_q.push_back(raw);
    if (raw_q.size() > SYNC + 1) void'(raw_q.pop_front());
    s = (raw_q.size() > SYNC) ? raw_q[raw_q.size() - 1 - SYNC] : 1'b0;
    m_rise = 1'b0;
    m_fall = 1'b0;
    if (s != m_d) begin
      m_run = m_run + 1;
      if (m_run == DC) begin
        m_d    = s;
        m_rise = s;
        m_fall = ~s;
        m_run  = 0;
      end
    end else begin
`ifdef DEBOUNCE_GLITCH_COUNT_EN
      if (m_run != 0 && m_glitch < 255) m_glitch = m_glitch + 1;
`endif
      m_run = 0;
    end
    m_busy = (m_run != 0);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 6; i++) begin
      bus.raw_in = (i % 2 == 0) ? 1'b1 : 1'(($urandom_range(0, 1)));
      @(posedge clk);
      #1;
      checks++;
      if ({bus.d_out, bus.rise_pulse, bus.fall_pulse, bus.busy} !== 4'b0000) begin
        errors++;
        $display("FAIL reset_outputs cyc=%0d got=%b expected=0000", i,
                 {bus.d_out, bus.rise_pulse, bus.fall_pulse, bus.busy});
      end
`ifdef DEBOUNCE_GLITCH_COUNT_EN
      checks++;
      if (bus.glitch_cnt !== 8'd0) begin
        errors++;
        $display("FAIL reset_glitch got=%0d expected=0", bus.glitch_cnt);
      end
`endif
    end
  endtask

  task automatic test_rise();
    int rise_edge, rise_cycles;
    rise_edge = 0;
    rise_cycles = 0;
    bus.raw_in = 1'b1;
    reset = 1'b1;
    for (int e = 1; e <= 9; e++) begin
      @(posedge clk);
      model_edge(1'b1);
      #1;
      checks++;
      if ({bus.d_out, bus.rise_pulse, bus.fall_pulse, bus.busy} !== {m_d, m_rise, m_fall, m_busy}) begin
        errors++;
        $display("FAIL rise_model edge=%0d got=%b expected=%b", e,
                 {bus.d_out, bus.rise_pulse, bus.fall_pulse, bus.busy}, {m_d, m_rise, m_fall, m_busy});
      end
      if (bus.rise_pulse === 1'b1) begin
        rise_edge = e;
        rise_cycles++;
      end
    end
    checks++;
    if (rise_edge != SYNC + DC || rise_cycles != 1) begin
      errors++;
      $display("FAIL rise_latency got edge=%0d width=%0d expected edge=%0d width=1",
               rise_edge, rise_cycles, SYNC + DC);
    end
  endtask

  task automatic test_fall();
    int fall_edge, rise_seen;
    fall_edge = 0;
    rise_seen = 0;
    bus.raw_in = 1'b0;
    for (int e = 1; e <= 9; e++) begin
      @(posedge clk);
      model_edge(1'b0);
      #1;
      checks++;
      if ({bus.d_out, bus.rise_pulse, bus.fall_pulse, bus.busy} !== {m_d, m_rise, m_fall, m_busy}) begin
        errors++;
        $display("FAIL fall_model edge=%0d got=%b expected=%b", e,
                 {bus.d_out, bus.rise_pulse, bus.fall_pulse, bus.busy}, {m_d, m_rise, m_fall, m_busy});
      end
      if (bus.fall_pulse === 1'b1) fall_edge = e;
      if (bus.rise_pulse === 1'b1) rise_seen++;
    end
    checks++;
    if (fall_edge != SYNC + DC || rise_seen != 0 || bus.d_out !== 1'b0) begin
      errors++;
      $display("FAIL fall_latency got edge=%0d rise=%0d d_out=%b expected edge=%0d rise=0 d_out=0",
               fall_edge, rise_seen, bus.d_out, SYNC + DC);
    end
  endtask

  task automatic test_glitch();
    int strobes;
    logic raw;
`ifdef DEBOUNCE_GLITCH_COUNT_EN
    int g0;
    g0 = m_glitch;
`endif
    strobes = 0;
    for (int e = 0; e < 10; e++) begin
      raw = (e < 3) ? 1'b1 : 1'b0;
      bus.raw_in = raw;
      @(posedge clk);
      model_edge(raw);
      #1;
      checks++;
      if ({bus.d_out, bus.rise_pulse, bus.fall_pulse, bus.busy} !== {m_d, m_rise, m_fall, m_busy}) begin
        errors++;
        $display("FAIL glitch_model edge=%0d got=%b expected=%b", e,
                 {bus.d_out, bus.rise_pulse, bus.fall_pulse, bus.busy}, {m_d, m_rise, m_fall, m_busy});
      end
      strobes += int'(bus.rise_pulse === 1'b1) + int'(bus.fall_pulse === 1'b1) + int'(bus.d_out !== 1'b0);
    end
    checks++;
    if (strobes != 0) begin
      errors++;
      $display("FAIL glitch_no_change got=%0d events expected=0", strobes);
    end
`ifdef DEBOUNCE_GLITCH_COUNT_EN
    checks++;
    if (int'(bus.glitch_cnt) != g0 + 1) begin
      errors++;
      $display("FAIL glitch_count got=%0d expected=%0d", bus.glitch_cnt, g0 + 1);
    end
`endif
  endtask

  task automatic test_reset_mid_arm();
    int strobes;
    strobes = 0;
    bus.raw_in = 1'b1;
    for (int e = 1; e <= SYNC + 2; e++) begin
      @(posedge clk);
      model_edge(1'b1);
      #1;
    end
    checks++;
    if (bus.busy !== 1'b1 || m_busy !== 1'b1) begin
      errors++;
      $display("FAIL midarm_busy got=%b expected=1", bus.busy);
    end
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({bus.d_out, bus.rise_pulse, bus.fall_pulse, bus.busy} !== 4'b0000) begin
      errors++;
      $display("FAIL midarm_async_clear got=%b expected=0000",
               {bus.d_out, bus.rise_pulse, bus.fall_pulse, bus.busy});
    end
    bus.raw_in = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int e = 0; e < 10; e++) begin
      @(posedge clk);
      model_edge(1'b0);
      #1;
      strobes += int'(bus.rise_pulse === 1'b1) + int'(bus.fall_pulse === 1'b1) + int'(bus.d_out !== 1'b0);
    end
    checks++;
    if (strobes != 0) begin
      errors++;
      $display("FAIL midarm_no_strobe got=%0d events expected=0", strobes);
    end
  endtask

  task automatic test_bounce_saturate();
    int changes;
    logic raw;
    changes = 0;
    for (int b = 0; b < 300; b++) begin
      for (int c = 0; c < 5; c++) begin
        raw = (c < 2) ? 1'b1 : 1'b0;
        bus.raw_in = raw;
        @(posedge clk);
        model_edge(raw);
        #1;
        changes += int'(bus.d_out !== 1'b0) + int'(bus.rise_pulse === 1'b1);
      end
    end
    checks++;
    if (changes != 0) begin
      errors++;
      $display("FAIL bounce_d_out got=%0d changes expected=0", changes);
    end
`ifdef DEBOUNCE_GLITCH_COUNT_EN
    checks++;
    if (bus.glitch_cnt !== 8'd255) begin
      errors++;
      $display("FAIL glitch_saturate got=%0d expected=255", bus.glitch_cnt);
    end
`endif
  endtask

  task automatic test_random();
    logic raw;
    int   hold;
    raw = 1'b0;
    for (int r = 0; r < 200; r++) begin
      raw  = ~raw;
      hold = int'($urandom_range(1, 8));
      for (int h = 0; h < hold; h++) begin
        bus.raw_in = raw;
        @(posedge clk);
        model_edge(raw);
        #1;
        checks++;
        if ({bus.d_out, bus.rise_pulse, bus.fall_pulse, bus.busy} !== {m_d, m_rise, m_fall, m_busy}) begin
          errors++;
          $display("FAIL random_model run=%0d got=%b expected=%b", r,
                   {bus.d_out, bus.rise_pulse, bus.fall_pulse, bus.busy}, {m_d, m_rise, m_fall, m_busy});
        end
`ifdef DEBOUNCE_GLITCH_COUNT_EN
        checks++;
        if (int'(bus.glitch_cnt) != m_glitch) begin
          errors++;
          $display("FAIL random_glitch run=%0d got=%0d expected=%0d", r, bus.glitch_cnt, m_glitch);
        end
`endif
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b0;
    bus.raw_in = 1'b0;
    #2;
    test_reset();
    test_rise();
    test_fall();
    test_glitch();
    test_reset_mid_arm();
    test_bounce_saturate();
    reset = 1'b0;
    model_reset();
    #3;
    reset = 1'b1;
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
